vga_fb_scheduler: RTL and testbench

Memory-port scheduler for a 160x120 framebuffer that is shown 4x upscaled on the 640x480 VGA raster. It shares one single-port synchronous pixel RAM between two users. The first is scanout prefetch, paced by the timing generator's `x`/`y`/`displayArea`. The second is a write client with a valid/ready handshake. The block also includes a hardware clear engine. It sits between the VGA timing generator, the drawing logic and the framebuffer RAM, all in the pixel clock domain.

---
 rtl/vga_fb_pkg.sv | 24 ++
 rtl/fb_addr_calc.sv | 12 +
 rtl/vga_fb_scheduler.sv | 156 +++++++++++++++
 tb/tb_vga_fb_scheduler.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_fb_pkg.sv
// Shared constants and FSM state type for the 160x120 framebuffer port scheduler.
package vga_fb_pkg;

   localparam int FB_W      = 160;
   localparam int FB_H      = 120;
   localparam int FB_ADDR_W = 15;
   localparam int FB_SIZE   = 19200;
   localparam int SCALE     = 4;

   localparam int H_TOTAL   = 800;
   localparam int V_TOTAL   = 525;
   localparam int H_VISIBLE = 640;
   localparam int V_VISIBLE = 480;

   // Line prefetch slot lands pix_reg exactly at x wrap; last group slot targets column FB_W-1.
   localparam int LINE_FETCH_X = H_TOTAL - 3;
   localparam int LAST_GRP_X   = (H_VISIBLE / SCALE - 2) * SCALE + 1;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } sched_state_e;

endpackage

// File: rtl/fb_addr_calc.sv
// Row/column to linear framebuffer address (row*160 + col) using shifts only.
module fb_addr_calc
   import vga_fb_pkg::*;
(
   input  logic [6:0]           row_i,
   input  logic [7:0]           col_i,
   output logic [FB_ADDR_W-1:0] addr_o
);

   assign addr_o = {1'b0, row_i, 7'b0} + {3'b0, row_i, 5'b0} + {7'b0, col_i};

endmodule

// File: rtl/vga_fb_scheduler.sv
// Single-port framebuffer RAM arbiter: scanout prefetch first, then clear engine, then writer.
//   state    | meaning
//   ST_IDLE  | writer may use port-free cycles
//   ST_CLEAR | fill engine owns port-free cycles, writer stalled
module vga_fb_scheduler
   import vga_fb_pkg::*;
#(
   parameter int PIX_W = 8
) (
   input  logic                 clk_pix,
   input  logic                 rst,
   input  logic [9:0]           x,
   input  logic [9:0]           y,
   input  logic                 displayArea,
   input  logic                 wr_valid,
   output logic                 wr_ready,
   input  logic [7:0]           wr_x,
   input  logic [6:0]           wr_y,
   input  logic [PIX_W-1:0]     wr_data,
   output logic                 wr_oob,
   input  logic                 clear_start,
   input  logic [PIX_W-1:0]     clear_color,
   output logic                 clear_busy,
   output logic [FB_ADDR_W-1:0] mem_addr,
   output logic                 mem_we,
   output logic [PIX_W-1:0]     mem_wdata,
   input  logic [PIX_W-1:0]     mem_rdata,
   output logic [PIX_W-1:0]     pix
);

   sched_state_e         state_q, state_d;
   logic [9:0]           next_line;
   logic                 fetch_line, fetch_grp, fetch_decision;
   logic [6:0]           calc_row;
   logic [7:0]           calc_col;
   logic [FB_ADDR_W-1:0] calc_addr;
   logic                 wr_fire, wr_in_range;
   logic                 clr_issue, clr_last;
   logic [FB_ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
   logic [PIX_W-1:0]     clr_color_q, clr_color_d;
   logic [1:0]           pend_q, pend_d;
   logic [PIX_W-1:0]     pix_reg_q, pix_reg_d;
   logic [FB_ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic                 mem_we_q, mem_we_d;
   logic [PIX_W-1:0]     mem_wdata_q, mem_wdata_d;
   logic                 wr_oob_q, wr_oob_d;

   assign next_line      = (y == 10'(V_TOTAL - 1)) ? 10'd0 : y + 10'd1;
   assign fetch_line     = (x == 10'(LINE_FETCH_X)) && (next_line < 10'(V_VISIBLE));
   assign fetch_grp      = (x[1:0] == 2'd1) && (x <= 10'(LAST_GRP_X)) && (y < 10'(V_VISIBLE));
   assign fetch_decision = fetch_line || fetch_grp;

   // Fetch and writer never need the mapper in the same cycle, so one instance serves both.
   assign calc_row = fetch_decision ? (fetch_line ? next_line[8:2] : y[8:2]) : wr_y;
   assign calc_col = fetch_decision ? (fetch_line ? 8'd0 : x[9:2] + 8'd1) : wr_x;

   fb_addr_calc u_addr_calc (
      .row_i  (calc_row),
      .col_i  (calc_col),
      .addr_o (calc_addr)
   );

   assign wr_in_range = (wr_x < 8'(FB_W)) && (wr_y < 7'(FB_H));
   assign wr_fire     = wr_valid && wr_ready;
   assign clr_issue   = (state_q == ST_CLEAR) && !fetch_decision;
   assign clr_last    = (clr_cnt_q == FB_ADDR_W'(FB_SIZE - 1));

   always_ff @(posedge clk_pix) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (clear_start) state_d = ST_CLEAR;
         ST_CLEAR: if (clr_issue && clr_last) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      wr_ready   = 1'b0;
      clear_busy = 1'b0;
      case (state_q)
         ST_IDLE:  wr_ready = !rst && !clear_start && !fetch_decision;
         ST_CLEAR: clear_busy = 1'b1;
         default:  wr_ready = 1'b0;
      endcase
   end

   always_comb begin
      mem_addr_d  = mem_addr_q;
      mem_we_d    = 1'b0;
      mem_wdata_d = mem_wdata_q;
      wr_oob_d    = 1'b0;
      clr_cnt_d   = clr_cnt_q;
      clr_color_d = clr_color_q;
      if (fetch_decision) begin
         mem_addr_d = calc_addr;
      end else if (clr_issue) begin
         mem_addr_d  = clr_cnt_q;
         mem_we_d    = 1'b1;
         mem_wdata_d = clr_color_q;
         clr_cnt_d   = clr_cnt_q + FB_ADDR_W'(1);
      end else if (wr_fire) begin
         if (wr_in_range) begin
            mem_addr_d  = calc_addr;
            mem_we_d    = 1'b1;
            mem_wdata_d = wr_data;
         end else begin
            wr_oob_d = 1'b1;
         end
      end
      if ((state_q == ST_IDLE) && clear_start) begin
         clr_cnt_d   = '0;
         clr_color_d = clear_color;
      end
   end

   // pend_q[1] marks the cycle in which mem_rdata belongs to a fetch.
   assign pend_d    = {pend_q[0], fetch_decision};
   assign pix_reg_d = pend_q[1] ? mem_rdata : pix_reg_q;

   always_ff @(posedge clk_pix) begin
      if (rst) begin
         mem_addr_q  <= '0;
         mem_we_q    <= 1'b0;
         mem_wdata_q <= '0;
         wr_oob_q    <= 1'b0;
         clr_cnt_q   <= '0;
         clr_color_q <= '0;
         pend_q      <= '0;
         pix_reg_q   <= '0;
      end else begin
         mem_addr_q  <= mem_addr_d;
         mem_we_q    <= mem_we_d;
         mem_wdata_q <= mem_wdata_d;
         wr_oob_q    <= wr_oob_d;
         clr_cnt_q   <= clr_cnt_d;
         clr_color_q <= clr_color_d;
         pend_q      <= pend_d;
         pix_reg_q   <= pix_reg_d;
      end
   end

   assign mem_addr  = mem_addr_q;
   assign mem_we    = mem_we_q;
   assign mem_wdata = mem_wdata_q;
   assign wr_oob    = wr_oob_q;
   assign pix       = displayArea ? pix_reg_q : '0;

endmodule

// File: tb/tb_vga_fb_scheduler.sv
// Directed bench for vga_fb_scheduler with a behavioural sync RAM and bench-driven raster position.
module tb_vga_fb_scheduler;

   localparam int PIX_W = 8;

   logic             clk_pix = 1'b0;
   logic             rst;
   logic [9:0]       x, y;
   logic             displayArea;
   logic             wr_valid, wr_ready;
   logic [7:0]       wr_x;
   logic [6:0]       wr_y;
   logic [PIX_W-1:0] wr_data;
   logic             wr_oob;
   logic             clear_start;
   logic [PIX_W-1:0] clear_color;
   logic             clear_busy;
   logic [14:0]      mem_addr;
   logic             mem_we;
   logic [PIX_W-1:0] mem_wdata, mem_rdata, pix;

   logic [PIX_W-1:0] ram [0:19199];
   logic             ram_init;
   int               errors = 0;
   int               checks = 0;

   vga_fb_scheduler #(.PIX_W(PIX_W)) dut (
      .clk_pix     (clk_pix),
      .rst         (rst),
      .x           (x),
      .y           (y),
      .displayArea (displayArea),
      .wr_valid    (wr_valid),
      .wr_ready    (wr_ready),
      .wr_x        (wr_x),
      .wr_y        (wr_y),
      .wr_data     (wr_data),
      .wr_oob      (wr_oob),
      .clear_start (clear_start),
      .clear_color (clear_color),
      .clear_busy  (clear_busy),
      .mem_addr    (mem_addr),
      .mem_we      (mem_we),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata),
      .pix         (pix)
   );

   always #5 clk_pix = ~clk_pix;

   always @(posedge clk_pix) begin
      if (ram_init) begin
         for (int i = 0; i < 19200; i++) ram[i] <= '0;
      end else if (mem_we && (mem_addr < 15'd19200)) begin
         ram[mem_addr] <= mem_wdata;
      end
      mem_rdata <= (mem_addr < 15'd19200) ? ram[mem_addr] : '0;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic set_xy(input int nx, input int ny);
      x = 10'(nx);
      y = 10'(ny);
      displayArea = (nx < 640) && (ny < 480);
   endtask

   task automatic cyc();
      @(posedge clk_pix);
      #1;
      if (x == 10'd799) set_xy(0, (y == 10'd524) ? 0 : int'(y) + 1);
      else set_xy(int'(x) + 1, int'(y));
      #1;
   endtask

   function automatic bit fd_model(input int px, input int py);
      int nl;
      nl = (py == 524) ? 0 : py + 1;
      return ((px == 797) && (nl < 480)) || ((px % 4 == 1) && (px <= 633) && (py < 480));
   endfunction

   initial begin
      int nw, bad_addr, bad_data, bad_slot, budget;
      bit prev_fd;

      rst = 1'b1; ram_init = 1'b1;
      wr_valid = 1'b0; wr_x = '0; wr_y = '0; wr_data = '0;
      clear_start = 1'b0; clear_color = '0;
      set_xy(0, 0);
      cyc();
      ram_init = 1'b0;
      cyc(); cyc();
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_we", mem_we, 0);
      check("rst_mem_wdata", mem_wdata, 0);
      check("rst_wr_oob", wr_oob, 0);
      check("rst_clear_busy", clear_busy, 0);
      check("rst_wr_ready", wr_ready, 0);
      check("rst_pix", pix, 0);

      rst = 1'b0; set_xy(5, 490); #1;
      check("idle_wr_ready", wr_ready, 1);

      // two in-range writes during vblank
      cyc();
      wr_valid = 1'b1; wr_x = 8'd3; wr_y = 7'd0; wr_data = 8'hA5; #1;
      check("wr_ready_vblank", wr_ready, 1);
      cyc();
      check("wr1_addr", mem_addr, 3);
      check("wr1_we", mem_we, 1);
      check("wr1_data", mem_wdata, 8'hA5);
      wr_x = 8'd159; wr_y = 7'd1; wr_data = 8'h77; #1;
      cyc();
      check("wr2_addr", mem_addr, 319);
      check("wr2_we", mem_we, 1);
      check("wr2_data", mem_wdata, 8'h77);
      wr_valid = 1'b0; #1;
      cyc();
      check("wr_we_one_cycle", mem_we, 0);

      // out-of-range writes
      wr_valid = 1'b1; wr_x = 8'd160; wr_y = 7'd5; wr_data = 8'hFF; #1;
      check("oob_ready", wr_ready, 1);
      cyc();
      wr_valid = 1'b0; #1;
      check("oob_col_pulse", wr_oob, 1);
      check("oob_col_no_we", mem_we, 0);
      check("oob_addr_hold", mem_addr, 319);
      cyc();
      check("oob_pulse_end", wr_oob, 0);
      wr_valid = 1'b1; wr_x = 8'd10; wr_y = 7'd120; #1;
      cyc();
      wr_valid = 1'b0; #1;
      check("oob_row_pulse", wr_oob, 1);
      check("oob_row_no_we", mem_we, 0);

      // line prefetch at end of last line
      set_xy(797, 524); #1;
      check("line_slot_ready", wr_ready, 0);
      cyc();
      check("line_fetch_addr", mem_addr, 0);
      check("line_fetch_we", mem_we, 0);
      cyc(); cyc(); cyc();
      check("at_x1_y0", {22'd0, x}, 1);

      // writer stalled by the group slot, accepted one cycle later
      wr_valid = 1'b1; wr_x = 8'd40; wr_y = 7'd100; wr_data = 8'h5A; #1;
      check("grp_slot_ready", wr_ready, 0);
      cyc();
      check("grp_fetch_addr", mem_addr, 1);
      check("grp_fetch_we", mem_we, 0);
      check("stall_then_ready", wr_ready, 1);
      cyc();
      wr_valid = 1'b0; #1;
      check("stalled_wr_addr", mem_addr, 16040);
      check("stalled_wr_we", mem_we, 1);
      check("stalled_wr_data", mem_wdata, 8'h5A);

      // scanout of the written pixels
      budget = 0;
      while (!((y == 10'd8) && (x == 10'd0)) && (budget < 10000)) begin
         cyc();
         budget++;
         if ((y <= 10'd3) && ((x == 10'd12) || (x == 10'd15))) check("scan_a5", pix, 8'hA5);
         if ((y <= 10'd3) && ((x == 10'd11) || (x == 10'd16))) check("scan_neigh", pix, 0);
         if ((y >= 10'd4) && (y <= 10'd7) && (x == 10'd636)) check("scan_77", pix, 8'h77);
         if ((y >= 10'd4) && (y <= 10'd7) && (x == 10'd640)) check("scan_blank_zero", pix, 0);
      end
      check("scan_budget", budget < 10000, 1);

      // full clear, started inside active lines so fetch slots interleave
      set_xy(0, 470);
      clear_start = 1'b1; clear_color = 8'h3C;
      wr_valid = 1'b1; wr_x = 8'd0; wr_y = 7'd0; wr_data = 8'hFF; #1;
      check("clr_blocks_wr", wr_ready, 0);
      cyc();
      clear_start = 1'b0; clear_color = 8'hEE; #1;
      check("clr_busy_rise", clear_busy, 1);
      check("clr_no_wr", mem_we, 0);
      check("clr_wr_ready", wr_ready, 0);
      wr_valid = 1'b0; #1;
      nw = 0; bad_addr = 0; bad_data = 0; bad_slot = 0; budget = 0;
      while (clear_busy && (budget < 30000)) begin
         prev_fd = fd_model(int'(x), int'(y));
         if (budget == 5000) begin
            clear_start = 1'b1; clear_color = 8'h99;
         end
         cyc();
         clear_start = 1'b0;
         budget++;
         if (mem_we) begin
            if (mem_addr != 15'(nw)) bad_addr++;
            if (mem_wdata != 8'h3C) bad_data++;
            if (prev_fd) bad_slot++;
            nw++;
            if (mem_addr == 15'd19199) check("clr_busy_fall", clear_busy, 0);
         end
      end
      cyc();
      check("clr_count", nw, 19200);
      check("clr_addr_seq", bad_addr, 0);
      check("clr_data", bad_data, 0);
      check("clr_fetch_slot", bad_slot, 0);
      check("clr_ram_first", ram[0], 8'h3C);
      check("clr_ram_last", ram[19199], 8'h3C);
      check("clr_ram_overwrote", ram[16040], 8'h3C);

      // reset in the middle of a clear
      set_xy(0, 490);
      clear_start = 1'b1; clear_color = 8'h42; #1;
      cyc();
      clear_start = 1'b0;
      nw = 0; budget = 0;
      while ((nw < 100) && (budget < 1000)) begin
         cyc();
         budget++;
         if (mem_we) nw++;
      end
      check("rst_clr_reached", nw, 100);
      rst = 1'b1;
      cyc();
      check("rst_clr_we", mem_we, 0);
      check("rst_clr_busy", clear_busy, 0);
      check("rst_clr_ready", wr_ready, 0);
      cyc();
      rst = 1'b0; #1;
      check("rel_wr_ready", wr_ready, 1);
      nw = 0;
      repeat (50) begin
         cyc();
         if (mem_we) nw++;
      end
      check("post_rst_no_we", nw, 0);
      check("post_rst_idle", clear_busy, 0);
      check("part_clear_99", ram[99], 8'h42);
      check("part_clear_100", ram[100], 8'h3C);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
